// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction-fetch stage: jump-select codes,
// FSM state codes and the NOP encoding loaded into IR at reset.
// No logic; imported by fetch_unit and pc_next_logic.
package fetch_unit_pkg;

    // pc_jump_sel encodings
    localparam logic JP_TO_F     = 1'b0;  // target = f_reg & ~1 (jalr)
    localparam logic JP_RELATIVE = 1'b1;  // target = pc_old + imm32 (jal/branch)

    // Fetch FSM state codes
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit_pc_next_logic.sv
// PC next-value logic: jump target, +4 increment, IDLE-state next PC, misalign hit.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the owning FSM decides when the results are registered.
//
// Ports: pc/pc_old/imm32/f_reg operands; pc_jump/pc_jump_sel/ir_write/pc_go_next
// commands; pc_inc = pc+4; pc_idle_nxt = PC to load in IDLE; misalign_hit =
// a jump this cycle targets a non-word-aligned address.
module pc_next_logic
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W = 32   // must be <= 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] pc_old,
    input  logic [31:0]       imm32,
    input  logic [31:0]       f_reg,
    input  logic              pc_jump,
    input  logic              pc_jump_sel,
    input  logic              ir_write,
    input  logic              pc_go_next,
    output logic [ADDR_W-1:0] pc_inc,
    output logic [ADDR_W-1:0] pc_idle_nxt,
    output logic              misalign_hit
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] LSB_CLR = {{(ADDR_W-1){1'b1}}, 1'b0};

    logic [ADDR_W-1:0] target;

    always_comb begin
        target       = '0;
        pc_inc       = pc + PC_STEP;
        pc_idle_nxt  = pc;
        misalign_hit = 1'b0;

        if (pc_jump_sel == JP_TO_F)
            target = f_reg[ADDR_W-1:0] & LSB_CLR;
        else
            target = pc_old + imm32[ADDR_W-1:0];

        // Priority: jump > ir_write > go_next. An ir_write keeps pc here;
        // its +4 is applied later, on the ack edge.
        if (pc_jump) begin
            pc_idle_nxt  = {target[ADDR_W-1:2], 2'b00};
            misalign_hit = target[1];
        end else if (!ir_write && pc_go_next) begin
            pc_idle_nxt = pc_inc;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch/PC stage: owns PC, PC_OLD, IR and the imem req/ack handshake.
// Latency: fetch is >= 2 edges (issue edge, then ack edge); PC updates take 1 edge.
// Backpressure: imem_req/imem_addr held until imem_ack; fetch_busy tells the CU to stall.
//
// Ports: clk, rst (async active-low); CU strobes pc_go_next/pc_jump/pc_jump_sel/
// ir_write; imm32/f_reg jump operands; imem_req/imem_addr/imem_rdata/imem_ack;
// pc, pc_old, ir and decoded fields; fetch_busy; sticky misalign.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_go_next,
    input  logic              pc_jump,
    input  logic              pc_jump_sel,
    input  logic              ir_write,
    input  logic [31:0]       imm32,
    input  logic [31:0]       f_reg,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ack,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_old,
    output logic [31:0]       ir,
    output logic [6:0]        opcode,
    output logic [2:0]        funct3,
    output logic [6:0]        funct7,
    output logic [4:0]        rs1,
    output logic [4:0]        rs2,
    output logic [4:0]        rd,
    output logic              fetch_busy,
    output logic              misalign
);

    localparam logic [ADDR_W-1:0] RST_PC = RESET_PC[ADDR_W-1:0];

    logic [0:0]        state;
    logic              inc_pending;   // pc_go_next seen with ir_write; apply at ack
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_idle_nxt;
    logic              misalign_hit;

    pc_next_logic #(.ADDR_W(ADDR_W)) u_pc_next (
        .pc           (pc),
        .pc_old       (pc_old),
        .imm32        (imm32),
        .f_reg        (f_reg),
        .pc_jump      (pc_jump),
        .pc_jump_sel  (pc_jump_sel),
        .ir_write     (ir_write),
        .pc_go_next   (pc_go_next),
        .pc_inc       (pc_inc),
        .pc_idle_nxt  (pc_idle_nxt),
        .misalign_hit (misalign_hit)
    );

    // The request and the busy flag are both exactly "a fetch is outstanding".
    assign imem_req   = (state == ST_WAIT);
    assign fetch_busy = (state == ST_WAIT);

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            pc          <= RST_PC;
            pc_old      <= RST_PC;
            ir          <= NOP_INSN;
            imem_addr   <= RST_PC;
            inc_pending <= 1'b0;
            misalign    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // imem_ack is ignored here: late/spurious responses drop.
                    pc       <= pc_idle_nxt;
                    misalign <= misalign | misalign_hit;
                    if (!pc_jump && ir_write) begin
                        imem_addr   <= pc;
                        inc_pending <= pc_go_next;
                        state       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Commands are ignored while the fetch is outstanding.
                    if (imem_ack) begin
                        ir     <= imem_rdata;
                        pc_old <= imem_addr;
                        if (inc_pending)
                            pc <= pc_inc;
                        inc_pending <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pc_go_next = 1'b0;
    logic        pc_jump = 1'b0;
    logic        pc_jump_sel = 1'b0;
    logic        ir_write = 1'b0;
    logic [31:0] imm32 = '0;
    logic [31:0] f_reg = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        imem_ack = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_old;
    logic [31:0] ir;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        fetch_busy;
    logic        misalign;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .pc_go_next  (pc_go_next),
        .pc_jump     (pc_jump),
        .pc_jump_sel (pc_jump_sel),
        .ir_write    (ir_write),
        .imm32       (imm32),
        .f_reg       (f_reg),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ack    (imem_ack),
        .pc          (pc),
        .pc_old      (pc_old),
        .ir          (ir),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7      (funct7),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .fetch_busy  (fetch_busy),
        .misalign    (misalign)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cmds();
        pc_go_next = 1'b0;
        pc_jump    = 1'b0;
        ir_write   = 1'b0;
        imem_ack   = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (pc !== 32'h0) $display("FAIL rst_pc: got %h want %h", pc, 32'h0); else n_pass++;
        n_checks++; if (pc_old !== 32'h0) $display("FAIL rst_pc_old: got %h want %h", pc_old, 32'h0); else n_pass++;
        n_checks++; if (ir !== 32'h0000_0013) $display("FAIL rst_ir: got %h want %h", ir, 32'h13); else n_pass++;
        n_checks++; if (opcode !== 7'h13) $display("FAIL rst_opcode: got %h want %h", opcode, 7'h13); else n_pass++;
        n_checks++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", imem_req); else n_pass++;
        n_checks++; if (imem_addr !== 32'h0) $display("FAIL rst_addr: got %h want 0", imem_addr); else n_pass++;
        n_checks++; if (fetch_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", fetch_busy); else n_pass++;
        n_checks++; if (misalign !== 1'b0) $display("FAIL rst_misalign: got %b want 0", misalign); else n_pass++;
        rst = 1'b1;
    endtask

    task automatic test_basic_fetch();
        ir_write = 1'b1; pc_go_next = 1'b1;
        tick();
        clear_cmds();
        n_checks++; if (imem_req !== 1'b1) $display("FAIL bf_req: got %b want 1", imem_req); else n_pass++;
        n_checks++; if (imem_addr !== 32'h0) $display("FAIL bf_addr: got %h want 0", imem_addr); else n_pass++;
        n_checks++; if (fetch_busy !== 1'b1) $display("FAIL bf_busy_hi: got %b want 1", fetch_busy); else n_pass++;
        n_checks++; if (pc !== 32'h0) $display("FAIL bf_pc_pre: got %h want 0", pc); else n_pass++;
        imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
        tick();
        clear_cmds();
        n_checks++; if (ir !== 32'h0050_0093) $display("FAIL bf_ir: got %h want %h", ir, 32'h00500093); else n_pass++;
        n_checks++; if (opcode !== 7'h13) $display("FAIL bf_opcode: got %h want 13", opcode); else n_pass++;
        n_checks++; if (rd !== 5'd1) $display("FAIL bf_rd: got %0d want 1", rd); else n_pass++;
        n_checks++; if (pc !== 32'h4) $display("FAIL bf_pc: got %h want 4", pc); else n_pass++;
        n_checks++; if (pc_old !== 32'h0) $display("FAIL bf_pc_old: got %h want 0", pc_old); else n_pass++;
        n_checks++; if (fetch_busy !== 1'b0) $display("FAIL bf_busy_lo: got %b want 0", fetch_busy); else n_pass++;
        n_checks++; if (imem_req !== 1'b0) $display("FAIL bf_req_lo: got %b want 0", imem_req); else n_pass++;
    endtask

    task automatic test_late_ack();
        ir_write = 1'b1; pc_go_next = 1'b1;
        tick();
        clear_cmds();
        // Commands pulsing during WAIT must be ignored.
        pc_jump = 1'b1; pc_jump_sel = JP_TO_F; f_reg = 32'h200; pc_go_next = 1'b1; ir_write = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (pc !== 32'h4) $display("FAIL la_pc_hold%0d: got %h want 4", i, pc); else n_pass++;
            n_checks++; if (imem_addr !== 32'h4) $display("FAIL la_addr_hold%0d: got %h want 4", i, imem_addr); else n_pass++;
            n_checks++; if (imem_req !== 1'b1) $display("FAIL la_req_hold%0d: got %b want 1", i, imem_req); else n_pass++;
        end
        clear_cmds();
        imem_ack = 1'b1; imem_rdata = 32'h0020_8133;  // add x2, x1, x2
        tick();
        clear_cmds();
        n_checks++; if (pc !== 32'h8) $display("FAIL la_pc: got %h want 8", pc); else n_pass++;
        n_checks++; if (pc_old !== 32'h4) $display("FAIL la_pc_old: got %h want 4", pc_old); else n_pass++;
        n_checks++; if (opcode !== 7'h33) $display("FAIL la_opcode: got %h want 33", opcode); else n_pass++;
        n_checks++; if (rs1 !== 5'd1) $display("FAIL la_rs1: got %0d want 1", rs1); else n_pass++;
        n_checks++; if (rs2 !== 5'd2) $display("FAIL la_rs2: got %0d want 2", rs2); else n_pass++;
        n_checks++; if (rd !== 5'd2) $display("FAIL la_rd: got %0d want 2", rd); else n_pass++;
        n_checks++; if (misalign !== 1'b0) $display("FAIL la_misalign: got %b want 0", misalign); else n_pass++;
        // Spurious ack in IDLE leaves IR alone.
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        clear_cmds();
        n_checks++; if (ir !== 32'h0020_8133) $display("FAIL sp_ir: got %h want %h", ir, 32'h00208133); else n_pass++;
        n_checks++; if (pc !== 32'h8) $display("FAIL sp_pc: got %h want 8", pc); else n_pass++;
    endtask

    task automatic test_jump();
        pc_go_next = 1'b1;
        tick(); tick();
        clear_cmds();
        n_checks++; if (pc !== 32'h10) $display("FAIL jp_step: got %h want 10", pc); else n_pass++;
        ir_write = 1'b1; pc_go_next = 1'b1;
        tick();
        clear_cmds();
        imem_ack = 1'b1; imem_rdata = 32'h0000_006F;
        tick();
        clear_cmds();
        n_checks++; if (pc !== 32'h14) $display("FAIL jp_fetch_pc: got %h want 14", pc); else n_pass++;
        n_checks++; if (pc_old !== 32'h10) $display("FAIL jp_fetch_pc_old: got %h want 10", pc_old); else n_pass++;
        pc_jump = 1'b1; pc_jump_sel = JP_RELATIVE; imm32 = 32'hFFFF_FFF8;
        tick();
        clear_cmds();
        n_checks++; if (pc !== 32'h8) $display("FAIL jp_rel: got %h want 8", pc); else n_pass++;
        pc_jump = 1'b1; pc_jump_sel = JP_TO_F; f_reg = 32'h0000_0101;
        tick();
        clear_cmds();
        n_checks++; if (pc !== 32'h100) $display("FAIL jp_tof: got %h want 100", pc); else n_pass++;
        n_checks++; if (misalign !== 1'b0) $display("FAIL jp_tof_misalign: got %b want 0", misalign); else n_pass++;
    endtask

    task automatic test_misalign();
        pc_jump = 1'b1; pc_jump_sel = JP_TO_F; f_reg = 32'h0000_0106;
        tick();
        clear_cmds();
        n_checks++; if (pc !== 32'h104) $display("FAIL ma_pc: got %h want 104", pc); else n_pass++;
        n_checks++; if (misalign !== 1'b1) $display("FAIL ma_set: got %b want 1", misalign); else n_pass++;
        ir_write = 1'b1;  // no pc_go_next: pc must stay put
        tick();
        clear_cmds();
        imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
        tick();
        clear_cmds();
        n_checks++; if (pc !== 32'h104) $display("FAIL ma_fetch_pc: got %h want 104", pc); else n_pass++;
        n_checks++; if (pc_old !== 32'h104) $display("FAIL ma_fetch_pc_old: got %h want 104", pc_old); else n_pass++;
        n_checks++; if (misalign !== 1'b1) $display("FAIL ma_sticky: got %b want 1", misalign); else n_pass++;
    endtask

    task automatic test_wrap_priority();
        pc_jump = 1'b1; pc_jump_sel = JP_TO_F; f_reg = 32'hFFFF_FFFC;
        tick();
        clear_cmds();
        n_checks++; if (pc !== 32'hFFFF_FFFC) $display("FAIL wr_setup: got %h want fffffffc", pc); else n_pass++;
        pc_go_next = 1'b1;
        tick();
        clear_cmds();
        n_checks++; if (pc !== 32'h0) $display("FAIL wr_wrap: got %h want 0", pc); else n_pass++;
        pc_jump = 1'b1; pc_jump_sel = JP_TO_F; f_reg = 32'h40; ir_write = 1'b1; pc_go_next = 1'b1;
        tick();
        clear_cmds();
        n_checks++; if (pc !== 32'h40) $display("FAIL pr_pc: got %h want 40", pc); else n_pass++;
        n_checks++; if (imem_req !== 1'b0) $display("FAIL pr_req: got %b want 0", imem_req); else n_pass++;
        n_checks++; if (fetch_busy !== 1'b0) $display("FAIL pr_busy: got %b want 0", fetch_busy); else n_pass++;
        tick();
        n_checks++; if (pc !== 32'h40) $display("FAIL pr_pc_settled: got %h want 40", pc); else n_pass++;
        n_checks++; if (misalign !== 1'b1) $display("FAIL pr_misalign_sticky: got %b want 1", misalign); else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        ir_write = 1'b1;
        tick();
        clear_cmds();
        n_checks++; if (imem_req !== 1'b1) $display("FAIL rm_req_pre: got %b want 1", imem_req); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b0) $display("FAIL rm_req_async: got %b want 0", imem_req); else n_pass++;
        n_checks++; if (pc !== 32'h0) $display("FAIL rm_pc: got %h want 0", pc); else n_pass++;
        n_checks++; if (ir !== 32'h0000_0013) $display("FAIL rm_ir: got %h want 13", ir); else n_pass++;
        n_checks++; if (misalign !== 1'b0) $display("FAIL rm_misalign: got %b want 0", misalign); else n_pass++;
        n_checks++; if (imem_addr !== 32'h0) $display("FAIL rm_addr: got %h want 0", imem_addr); else n_pass++;
        #2;
        rst = 1'b1;
        imem_ack = 1'b1; imem_rdata = 32'hAAAA_AAAA;
        tick();
        clear_cmds();
        n_checks++; if (ir !== 32'h0000_0013) $display("FAIL rm_late_ack_ir: got %h want 13", ir); else n_pass++;
        n_checks++; if (pc_old !== 32'h0) $display("FAIL rm_late_ack_pc_old: got %h want 0", pc_old); else n_pass++;
        n_checks++; if (fetch_busy !== 1'b0) $display("FAIL rm_late_ack_busy: got %b want 0", fetch_busy); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_late_ack();
        test_jump();
        test_misalign();
        test_wrap_priority();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
